// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ cores.
// The winner's request is latched, run on the memory port, and answered with a one-cycle done strobe.
module mem_port_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned WORD_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2*NREQ-1:0]          req_rw,
   input  logic [ADDR_W*NREQ-1:0]     req_addr,
   input  logic [WORD_W*NREQ-1:0]     req_wdata,
   output logic [NREQ-1:0]            rd_en,
   output logic [NREQ-1:0]            wt_en,
   output logic [WORD_W-1:0]          rdata,
   output logic [1:0]                 mem_rw,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [WORD_W-1:0]          mem_wdata,
   input  logic                       mem_rd_done,
   input  logic                       mem_wt_done,
   input  logic [WORD_W-1:0]          mem_rdata,
   output logic                       busy,
   output logic [$clog2(NREQ)-1:0]    grant_id,
   output logic                       err_illegal
);

   localparam int unsigned IDW = $clog2(NREQ);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

   state_t            state;
   logic [IDW-1:0]    ptr;
   logic [1:0]        op_a   [NREQ];
   logic [ADDR_W-1:0] addr_a [NREQ];
   logic [WORD_W-1:0] wd_a   [NREQ];
   logic [NREQ-1:0]   req_v;
   logic              any_ill;
   logic              found;
   logic [IDW-1:0]    win;
   logic [IDW-1:0]    scan_idx;

   // Split the flat request buses into per-core fields.
   always_comb begin
      any_ill = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i]   = req_rw[2*i +: 2];
         addr_a[i] = req_addr[ADDR_W*i +: ADDR_W];
         wd_a[i]   = req_wdata[WORD_W*i +: WORD_W];
         req_v[i]  = (op_a[i] == 2'd1) || (op_a[i] == 2'd2);
         if (op_a[i] == 2'd3) any_ill = 1'b1;
      end
   end

   // First requesting core at or above the pointer, wrapping.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = IDW'((32'(ptr) + 32'(k)) % NREQ);
         if (!found && req_v[scan_idx]) begin
            found = 1'b1;
            win   = scan_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         rd_en       <= '0;
         wt_en       <= '0;
         rdata       <= '0;
         mem_rw      <= 2'd0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         busy        <= 1'b0;
         grant_id    <= '0;
         err_illegal <= 1'b0;
      end else begin
         if (any_ill) err_illegal <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (found) begin
                  mem_rw    <= op_a[win];
                  mem_addr  <= addr_a[win];
                  mem_wdata <= wd_a[win];
                  grant_id  <= win;
                  busy      <= 1'b1;
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Only the done that matches the latched op completes it.
               if (mem_rw == 2'd1 && mem_rd_done) begin
                  rdata  <= mem_rdata;
                  rd_en  <= NREQ'(1) << grant_id;
                  mem_rw <= 2'd0;
                  state  <= ST_RESP;
               end else if (mem_rw == 2'd2 && mem_wt_done) begin
                  wt_en  <= NREQ'(1) << grant_id;
                  mem_rw <= 2'd0;
                  state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               rd_en <= '0;
               wt_en <= '0;
               busy  <= 1'b0;
               ptr   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned WORD_W = 16;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [2*NREQ-1:0]      req_rw;
   logic [ADDR_W*NREQ-1:0] req_addr;
   logic [WORD_W*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]        rd_en, wt_en;
   logic [WORD_W-1:0]      rdata;
   logic [1:0]             mem_rw;
   logic [ADDR_W-1:0]      mem_addr;
   logic [WORD_W-1:0]      mem_wdata;
   logic                   mem_rd_done, mem_wt_done;
   logic [WORD_W-1:0]      mem_rdata;
   logic                   busy;
   logic [1:0]             grant_id;
   logic                   err_illegal;

   mem_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
      .clk(clk), .reset(reset), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
      .rd_en(rd_en), .wt_en(wt_en), .rdata(rdata), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rd_done(mem_rd_done), .mem_wt_done(mem_wt_done),
      .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Bench-side cores
   logic [1:0]        c_op   [NREQ];
   logic [ADDR_W-1:0] c_addr [NREQ];
   logic [WORD_W-1:0] c_wd   [NREQ];
   int                pend   [NREQ];
   logic [1:0]        op_cfg = 2'd1;

   // Memory responder configuration
   int                bc = 0, lat = 0, lat_cfg = 1;
   bit                rand_mode = 0, stray = 0, noise = 0, rd_fixed = 0;
   logic [WORD_W-1:0] rd_val = '0;

   // Model: phase 0 = waiting for requests, 1 = memory op outstanding, 2 = answering
   int                m_phase = 0, m_ptr = 0, m_gid = 0;
   logic [1:0]        m_op = 2'd0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [WORD_W-1:0] m_wdata = '0;
   logic [NREQ-1:0]   m_rd_en = '0, m_wt_en = '0;
   logic [WORD_W-1:0] m_rdata = '0;
   bit                m_busy = 0, m_err = 0;
   int                waitc [NREQ];
   int                grants [$];
   int                exp_order [5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_req(input logic [1:0] op);
      return (op == 2'd1) || (op == 2'd2);
   endfunction

   task automatic pack();
      for (int i = 0; i < NREQ; i++) begin
         req_rw[2*i +: 2]              = c_op[i];
         req_addr[ADDR_W*i +: ADDR_W]  = c_addr[i];
         req_wdata[WORD_W*i +: WORD_W] = c_wd[i];
      end
   endtask

   task automatic model_step();
      bit found;
      int w;
      if (reset) begin
         m_phase = 0; m_ptr = 0; m_gid = 0; m_op = 2'd0; m_addr = '0; m_wdata = '0;
         m_rd_en = '0; m_wt_en = '0; m_rdata = '0; m_busy = 0; m_err = 0;
         for (int i = 0; i < NREQ; i++) waitc[i] = 0;
         return;
      end
      for (int i = 0; i < NREQ; i++) if (c_op[i] == 2'd3) m_err = 1;
      case (m_phase)
         0: begin
            found = 0; w = 0;
            for (int k = 0; k < NREQ; k++) begin
               int idx;
               idx = (m_ptr + k) % NREQ;
               if (!found && is_req(c_op[idx])) begin found = 1; w = idx; end
            end
            if (found) begin
               for (int i = 0; i < NREQ; i++)
                  if (i != w && is_req(c_op[i])) begin
                     waitc[i]++;
                     chk("fairness_wait", 32'(waitc[i] < NREQ), 32'd1);
                  end
               waitc[w] = 0;
               grants.push_back(w);
               m_op = c_op[w]; m_addr = c_addr[w]; m_wdata = c_wd[w];
               m_gid = w; m_busy = 1; m_phase = 1;
            end
         end
         1: begin
            if (m_op == 2'd1 && mem_rd_done) begin
               m_rdata = mem_rdata; m_rd_en = NREQ'(1) << m_gid; m_op = 2'd0; m_phase = 2;
            end else if (m_op == 2'd2 && mem_wt_done) begin
               m_wt_en = NREQ'(1) << m_gid; m_op = 2'd0; m_phase = 2;
            end
         end
         default: begin
            m_rd_en = '0; m_wt_en = '0; m_busy = 0;
            m_ptr = (m_gid + 1) % NREQ; m_phase = 0;
         end
      endcase
   endtask

   task automatic check_all();
      chk("mem_rw", 32'(mem_rw), 32'(m_op));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("rd_en", 32'(rd_en), 32'(m_rd_en));
      chk("wt_en", 32'(wt_en), 32'(m_wt_en));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("err_illegal", 32'(err_illegal), 32'(m_err));
   endtask

   task automatic cores_update();
      for (int i = 0; i < NREQ; i++) begin
         if (m_rd_en[i] || m_wt_en[i]) c_op[i] = 2'd0;
         else if (c_op[i] == 2'd0 && pend[i] > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
            c_op[i]   = rand_mode ? 2'($urandom_range(1, 2)) : op_cfg;
            c_addr[i] = ADDR_W'($urandom);
            c_wd[i]   = WORD_W'($urandom);
            pend[i]--;
         end else if (rand_mode && is_req(c_op[i]) && $urandom_range(0, 3) == 0) begin
            c_addr[i] = ADDR_W'($urandom);
            c_wd[i]   = WORD_W'($urandom);
         end
      end
   endtask

   // One clock: drive memory + cores, advance model, compare at the falling edge.
   task automatic cycle();
      int old_phase;
      mem_rd_done = 1'b0; mem_wt_done = 1'b0;
      mem_rdata = rd_fixed ? rd_val : WORD_W'($urandom);
      if (m_phase == 1) begin
         if (bc == lat) begin
            if (m_op == 2'd1) mem_rd_done = 1'b1; else mem_wt_done = 1'b1;
         end else if (stray || (rand_mode && $urandom_range(0, 1) == 1)) begin
            if (m_op == 2'd1) mem_wt_done = 1'b1; else mem_rd_done = 1'b1;
         end
      end else if (noise) begin
         mem_rd_done = 1'($urandom_range(0, 1));
         mem_wt_done = 1'($urandom_range(0, 1));
      end
      pack();
      old_phase = m_phase;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
      if (m_phase == 1) begin
         if (old_phase != 1) begin
            bc = 0;
            lat = rand_mode ? $urandom_range(0, 3) : lat_cfg;
         end else bc++;
      end
      cores_update();
   endtask

   task automatic wait_strobe(input int max, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while ((rd_en | wt_en) == '0 && n < max);
      chk("strobe_seen", 32'((rd_en | wt_en) != '0), 32'd1);
   endtask

   task automatic drain();
      bit idle;
      int n;
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      n = 0;
      idle = 0;
      while (!idle && n < 200) begin
         cycle();
         n++;
         idle = (m_phase == 0);
         for (int i = 0; i < NREQ; i++) if (c_op[i] != 2'd0) idle = 0;
      end
      chk("drain_done", 32'(idle), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < NREQ; i++) begin
         c_op[i] = 2'd0; c_addr[i] = '0; c_wd[i] = '0; pend[i] = 0; waitc[i] = 0;
      end
      reset = 1'b1;
      mem_rd_done = 1'b0; mem_wt_done = 1'b0; mem_rdata = '0;
      pack();
      cycle();
      cycle();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_rw", 32'(mem_rw), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      reset = 1'b0;

      // Core 2 read, memory answers 3 cycles after mem_rw goes high
      rd_fixed = 1; rd_val = 16'hBEEF; lat_cfg = 3;
      c_op[2] = 2'd1; c_addr[2] = 16'h0010;
      cycle();
      chk("t1_mem_rw", 32'(mem_rw), 32'd1);
      chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
      wait_strobe(10, n);
      chk("t1_latency", 32'(n), 32'd4);
      chk("t1_rd_en", 32'(rd_en), 32'b0100);
      chk("t1_rdata", 32'(rdata), 32'hBEEF);
      chk("t1_grant", 32'(grant_id), 32'd2);
      cycle();
      chk("t1_strobe_once", 32'(rd_en), 32'd0);
      rd_fixed = 0;

      // Core 1 write with zero-wait memory
      lat_cfg = 0;
      c_op[1] = 2'd2; c_addr[1] = 16'h0020; c_wd[1] = 16'h1234;
      cycle();
      chk("t2_mem_wdata", 32'(mem_wdata), 32'h1234);
      wait_strobe(10, n);
      chk("t2_latency", 32'(n), 32'd1);
      chk("t2_wt_en", 32'(wt_en), 32'b0010);
      chk("t2_mem_rw0", 32'(mem_rw), 32'd0);
      chk("t2_rdata_hold", 32'(rdata), 32'hBEEF);
      cycle();

      // All cores reading continuously from a fresh pointer
      reset = 1'b1; cycle(); reset = 1'b0;
      grants.delete();
      lat_cfg = 1; op_cfg = 2'd1;
      for (int i = 0; i < NREQ; i++) begin c_op[i] = 2'd1; pend[i] = 3; end
      n = 0;
      while (grants.size() < 5 && n < 100) begin cycle(); n++; end
      chk("t3_grant_count", 32'(grants.size() >= 5), 32'd1);
      if (grants.size() >= 5)
         for (int j = 0; j < 5; j++) chk("t3_grant_order", 32'(grants[j]), 32'(exp_order[j]));
      drain();

      // Core 0 read with stray write-done pulses while waiting
      stray = 1; lat_cfg = 3;
      c_op[0] = 2'd1; c_addr[0] = 16'h0040;
      cycle();
      wait_strobe(10, n);
      chk("t4_latency", 32'(n), 32'd4);
      chk("t4_rd_en", 32'(rd_en), 32'b0001);
      stray = 0;
      cycle();

      // Illegal op on core 3 alongside a legal read on core 0
      lat_cfg = 1;
      c_op[3] = 2'd3; c_op[0] = 2'd1;
      cycle();
      chk("t5_err", 32'(err_illegal), 32'd1);
      wait_strobe(10, n);
      chk("t5_rd_en", 32'(rd_en), 32'b0001);
      chk("t5_grant", 32'(grant_id), 32'd0);
      for (int j = 0; j < 10; j++) cycle();
      chk("t5_not_granted", 32'(busy), 32'd0);
      c_op[3] = 2'd0;
      cycle();
      chk("t5_err_sticky", 32'(err_illegal), 32'd1);

      // Reset in the middle of a long memory wait
      lat_cfg = 20;
      for (int i = 1; i < NREQ; i++) c_op[i] = 2'd1;
      cycle(); cycle(); cycle();
      chk("t6_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      cycle();
      chk("t6_mem_rw", 32'(mem_rw), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_no_strobe", 32'(rd_en | wt_en), 32'd0);
      chk("t6_err_cleared", 32'(err_illegal), 32'd0);
      reset = 1'b0;
      lat_cfg = 1;
      c_op[0] = 2'd1;
      wait_strobe(10, n);
      chk("t6_grant0", 32'(grant_id), 32'd0);
      chk("t6_rd_en", 32'(rd_en), 32'b0001);
      drain();

      // Random traffic with latching, stray and idle-time done noise
      rand_mode = 1; noise = 1;
      for (int i = 0; i < NREQ; i++) pend[i] = $urandom_range(20, 40);
      for (int j = 0; j < 1500; j++) cycle();
      rand_mode = 0; noise = 0; lat_cfg = 1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
